// File: rtl/r88_regseq_if.sv
// Command and register-block strobe bundle for the Rocket88 register-transfer sequencer.
// The master side is the sequencer; the slave side is the control unit plus register block.
interface r88_regseq_if;
  logic       cmdValid;
  logic       cmdReady;
  logic [2:0] cmd;
  logic [3:0] srcSel;
  logic [3:0] dstSel;
  logic [3:0] regSel;
  logic       regRead;
  logic       regWrite;
  logic [7:0] busIn;
  logic [7:0] busOut;
  logic       busDrive;
  logic       busy;
  logic       done;
  logic       err;
  logic       wrapOut;

  modport master (
    input  cmdValid, cmd, srcSel, dstSel, busIn,
    output cmdReady, regSel, regRead, regWrite, busOut, busDrive, busy, done, err, wrapOut
  );

  modport slave (
    output cmdValid, cmd, srcSel, dstSel, busIn,
    input  cmdReady, regSel, regRead, regWrite, busOut, busDrive, busy, done, err, wrapOut
  );
endinterface

// File: rtl/r88_regseq.sv
// Rocket88 register-transfer sequencer: runs 8/16-bit moves, pair inc/dec and clears
// as timed regSel/regRead/regWrite strobes with intD drive cycles.
//
// state | meaning
// IDLE  | waiting for a command, cmdReady high
// RD1   | read strobe, register block loads its output buffer
// RD2   | read strobe, busIn captured into dataReg
// WR    | write strobe, busOut driven with the computed byte
// ERR   | command rejected, err pulse
// DONE  | command complete, done pulse with wrapOut
module r88_regseq (
  input  logic      sysClock,
  input  logic      sysReset,
  r88_regseq_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, ERR, DONE} seqStateT;

  localparam logic [2:0] CMD_MOV8  = 3'd0;
  localparam logic [2:0] CMD_MOV16 = 3'd1;
  localparam logic [2:0] CMD_INC16 = 3'd2;
  localparam logic [2:0] CMD_DEC16 = 3'd3;
  localparam logic [2:0] CMD_CLR8  = 3'd4;

  seqStateT   state, nextState;
  logic       phase, nextPhase;
  logic [2:0] opCmd;
  logic [3:0] opSrc, opDst;
  logic [7:0] dataReg;
  logic       carryReg;
  logic       wrapReg;
  logic       cmdLegal;
  logic       is16;
  logic [7:0] wrData;
  logic       wrCarry;

  logic       cmdReady, busy, done, err, wrapOut;
  logic       regRead, regWrite, busDrive;
  logic [3:0] regSel;
  logic [7:0] busOut;

  function automatic logic isPair(input logic [3:0] idx);
    return (idx == 4'd3) || (idx == 4'd5) || (idx == 4'd7) || (idx == 4'd9);
  endfunction

  always_comb begin
    cmdLegal = 1'b0;
    case (bus.cmd)
      CMD_MOV8:             cmdLegal = (bus.srcSel <= 4'd11) && (bus.dstSel <= 4'd10);
      CMD_MOV16:            cmdLegal = isPair(bus.srcSel) && isPair(bus.dstSel);
      CMD_INC16, CMD_DEC16: cmdLegal = isPair(bus.dstSel);
      CMD_CLR8:             cmdLegal = (bus.dstSel <= 4'd10);
      default:              cmdLegal = 1'b0;
    endcase
  end

  assign is16 = (opCmd == CMD_MOV16) || (opCmd == CMD_INC16) || (opCmd == CMD_DEC16);

  // Low byte applies +/-1; high byte applies the carry/borrow held from the low byte.
  always_comb begin
    wrData  = dataReg;
    wrCarry = 1'b0;
    case (opCmd)
      CMD_INC16: {wrCarry, wrData} = {1'b0, dataReg} + (phase ? {8'd0, carryReg} : 9'd1);
      CMD_DEC16: {wrCarry, wrData} = {1'b0, dataReg} - (phase ? {8'd0, carryReg} : 9'd1);
      CMD_CLR8:  wrData = 8'h00;
      default:   wrData = dataReg;
    endcase
  end

  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      state    <= IDLE;
      phase    <= 1'b0;
      opCmd    <= CMD_MOV8;
      opSrc    <= 4'd0;
      opDst    <= 4'd0;
      dataReg  <= 8'h00;
      carryReg <= 1'b0;
      wrapReg  <= 1'b0;
    end else begin
      state <= nextState;
      phase <= nextPhase;
      if (state == IDLE && bus.cmdValid) begin
        opCmd   <= bus.cmd;
        opSrc   <= (bus.cmd == CMD_INC16 || bus.cmd == CMD_DEC16) ? bus.dstSel : bus.srcSel;
        opDst   <= bus.dstSel;
        wrapReg <= 1'b0;
      end
      if (state == RD2) dataReg <= bus.busIn;
      if (state == WR) begin
        if (!phase) carryReg <= wrCarry;
        else        wrapReg  <= wrCarry;
      end
    end
  end

  always_comb begin
    nextState = state;
    nextPhase = phase;
    cmdReady  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    wrapOut   = 1'b0;
    regSel    = 4'd0;
    regRead   = 1'b0;
    regWrite  = 1'b0;
    busDrive  = 1'b0;
    busOut    = 8'h00;
    case (state)
      IDLE: begin
        cmdReady  = 1'b1;
        nextPhase = 1'b0;
        if (bus.cmdValid) begin
          if (!cmdLegal)               nextState = ERR;
          else if (bus.cmd == CMD_CLR8) nextState = WR;
          else                         nextState = RD1;
        end
      end
      RD1: begin
        regSel    = opSrc + {3'b000, phase};
        regRead   = 1'b1;
        nextState = RD2;
      end
      RD2: begin
        regSel    = opSrc + {3'b000, phase};
        regRead   = 1'b1;
        nextState = WR;
      end
      WR: begin
        regSel   = opDst + {3'b000, phase};
        regWrite = 1'b1;
        busDrive = 1'b1;
        busOut   = wrData;
        if (is16 && !phase) begin
          nextState = RD1;
          nextPhase = 1'b1;
        end else begin
          nextState = DONE;
        end
      end
      ERR: begin
        err       = 1'b1;
        nextState = IDLE;
      end
      DONE: begin
        done      = 1'b1;
        wrapOut   = wrapReg;
        nextState = IDLE;
        nextPhase = 1'b0;
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.cmdReady = cmdReady;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.wrapOut  = wrapOut;
  assign bus.regSel   = regSel;
  assign bus.regRead  = regRead;
  assign bus.regWrite = regWrite;
  assign bus.busDrive = busDrive;
  assign bus.busOut   = busOut;
endmodule

// File: tb/tb_r88_regseq.sv
// Directed bench for r88_regseq with a small register-block model on the strobes.
module tb_r88_regseq;
  logic sysClock;
  logic sysReset;
  r88_regseq_if bus ();

  r88_regseq dut (.sysClock(sysClock), .sysReset(sysReset), .bus(bus));

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  int nChecks = 0;
  int nFails  = 0;

  // Register block model: read buffer loads on regRead, writes land on regWrite.
  logic [7:0] regs [0:15];
  logic [7:0] outBuf;
  logic       pokeEn;
  logic [3:0] pokeIdx;
  logic [7:0] pokeVal;

  assign bus.busIn = outBuf;

  always @(posedge sysClock) begin
    if (pokeEn) regs[pokeIdx] <= pokeVal;
    else if (bus.regWrite && bus.busDrive && bus.regSel <= 4'd10) regs[bus.regSel] <= bus.busOut;
    if (bus.regRead) outBuf <= regs[bus.regSel];
  end

  always @(negedge sysClock) begin
    if (!sysReset) begin
      nChecks++;
      if ((bus.regRead && bus.busDrive) || (bus.regRead && bus.regWrite)) begin
        nFails++;
        $display("FAIL bus_safety: regRead=%0b regWrite=%0b busDrive=%0b required no overlap",
                 bus.regRead, bus.regWrite, bus.busDrive);
      end
    end
  end

  logic [3:0] trSel   [1:9];
  logic       trRd    [1:9];
  logic       trWr    [1:9];
  logic       trDrv   [1:9];
  logic [7:0] trOut   [1:9];
  logic       trReady [1:9];
  logic       trBusy  [1:9];
  int         doneCyc, errCyc;
  logic       doneWrap;

  task automatic step();
    @(posedge sysClock);
    #1;
  endtask

  task automatic poke(input logic [3:0] idx, input logic [7:0] val);
    pokeIdx = idx;
    pokeVal = val;
    pokeEn  = 1'b1;
    step();
    pokeEn  = 1'b0;
  endtask

  task automatic waitReady();
    int guard = 0;
    while (!bus.cmdReady && guard < 20) begin
      step();
      guard++;
    end
  endtask

  // Issues one command, scrambles the inputs after acceptance, and traces cycles 1..9.
  task automatic runCmd(input logic [2:0] c, input logic [3:0] s, input logic [3:0] d);
    waitReady();
    bus.cmdValid = 1'b1;
    bus.cmd      = c;
    bus.srcSel   = s;
    bus.dstSel   = d;
    step();
    bus.cmdValid = 1'b0;
    bus.cmd      = 3'd6;
    bus.srcSel   = 4'hF;
    bus.dstSel   = 4'hF;
    doneCyc  = -1;
    errCyc   = -1;
    doneWrap = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      trSel[i]   = bus.regSel;
      trRd[i]    = bus.regRead;
      trWr[i]    = bus.regWrite;
      trDrv[i]   = bus.busDrive;
      trOut[i]   = bus.busOut;
      trReady[i] = bus.cmdReady;
      trBusy[i]  = bus.busy;
      if (bus.done && doneCyc < 0) begin
        doneCyc  = i;
        doneWrap = bus.wrapOut;
      end
      if (bus.err && errCyc < 0) errCyc = i;
      step();
    end
  endtask

  task automatic test_reset();
    sysReset = 1'b1;
    step();
    step();
    nChecks++;
    if ({bus.cmdReady, bus.busy, bus.done, bus.err, bus.wrapOut, bus.regRead, bus.regWrite,
         bus.busDrive, bus.regSel, bus.busOut} !== {1'b1, 7'b0, 4'h0, 8'h00}) begin
      nFails++;
      $display("FAIL reset_during: ready=%0b busy=%0b regSel=%0h busOut=%0h required ready=1 rest 0",
               bus.cmdReady, bus.busy, bus.regSel, bus.busOut);
    end
    sysReset = 1'b0;
    step();
    nChecks++;
    if ({bus.cmdReady, bus.busy, bus.done, bus.err, bus.wrapOut, bus.regRead, bus.regWrite,
         bus.busDrive, bus.regSel, bus.busOut} !== {1'b1, 7'b0, 4'h0, 8'h00}) begin
      nFails++;
      $display("FAIL reset_after: ready=%0b busy=%0b regSel=%0h busOut=%0h required ready=1 rest 0",
               bus.cmdReady, bus.busy, bus.regSel, bus.busOut);
    end
  endtask

  task automatic test_mov8();
    poke(4'd0, 8'h5A);
    poke(4'd1, 8'h00);
    runCmd(3'd0, 4'd0, 4'd1);
    nChecks++;
    if ({trRd[1], trSel[1], trRd[2], trSel[2], trWr[1], trWr[2]} !== {1'b1, 4'd0, 1'b1, 4'd0, 2'b00}) begin
      nFails++;
      $display("FAIL mov8_read: rd=%0b%0b sel=%0h,%0h required rd=11 sel=0,0", trRd[1], trRd[2], trSel[1], trSel[2]);
    end
    nChecks++;
    if ({trWr[3], trDrv[3], trRd[3], trSel[3], trOut[3]} !== {3'b110, 4'd1, 8'h5A}) begin
      nFails++;
      $display("FAIL mov8_write: wr=%0b drv=%0b sel=%0h out=%0h required wr=1 drv=1 sel=1 out=5a",
               trWr[3], trDrv[3], trSel[3], trOut[3]);
    end
    nChecks++;
    if (doneCyc !== 4) begin
      nFails++;
      $display("FAIL mov8_done_cycle: got %0d required 4", doneCyc);
    end
    nChecks++;
    if ({trReady[1], trBusy[1], trReady[5], trBusy[5]} !== 4'b0110) begin
      nFails++;
      $display("FAIL mov8_ready: c1 ready=%0b busy=%0b c5 ready=%0b busy=%0b required 0,1,1,0",
               trReady[1], trBusy[1], trReady[5], trBusy[5]);
    end
    nChecks++;
    if (regs[1] !== 8'h5A) begin
      nFails++;
      $display("FAIL mov8_dest: B=%0h required 5a", regs[1]);
    end
  endtask

  task automatic test_inc16();
    logic [7:0] expLo [2];
    logic [7:0] expHi [2];
    logic       expWrap [2];
    expLo = '{8'h00, 8'h00};
    expHi = '{8'h01, 8'h00};
    expWrap = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      poke(4'd3, 8'hFF);
      poke(4'd4, (t == 0) ? 8'h00 : 8'hFF);
      runCmd(3'd2, 4'd0, 4'd3);
      nChecks++;
      if ({trSel[1], trSel[3], trOut[3], trSel[4], trSel[6], trOut[6]} !== {4'd3, 4'd3, expLo[t], 4'd4, 4'd4, expHi[t]}) begin
        nFails++;
        $display("FAIL inc16_writes[%0d]: sel=%0h,%0h,%0h,%0h out=%0h,%0h required 3,3,4,4 out=%0h,%0h",
                 t, trSel[1], trSel[3], trSel[4], trSel[6], trOut[3], trOut[6], expLo[t], expHi[t]);
      end
      nChecks++;
      if ({doneCyc == 7, doneWrap} !== {1'b1, expWrap[t]}) begin
        nFails++;
        $display("FAIL inc16_done[%0d]: cycle=%0d wrap=%0b required cycle 7 wrap=%0b", t, doneCyc, doneWrap, expWrap[t]);
      end
      nChecks++;
      if ({regs[4], regs[3]} !== {expHi[t], expLo[t]}) begin
        nFails++;
        $display("FAIL inc16_dest[%0d]: DD=%0h required %0h", t, {regs[4], regs[3]}, {expHi[t], expLo[t]});
      end
    end
  endtask

  task automatic test_dec16();
    poke(4'd9, 8'h00);
    poke(4'd10, 8'h00);
    runCmd(3'd3, 4'd2, 4'd9);
    nChecks++;
    if ({trSel[1], trSel[3], trOut[3], trSel[4], trSel[6], trOut[6]} !== {4'd9, 4'd9, 8'hFF, 4'd10, 4'd10, 8'hFF}) begin
      nFails++;
      $display("FAIL dec16_writes: sel=%0h,%0h,%0h,%0h out=%0h,%0h required 9,9,a,a out=ff,ff",
               trSel[1], trSel[3], trSel[4], trSel[6], trOut[3], trOut[6]);
    end
    nChecks++;
    if ({doneCyc == 7, doneWrap, regs[10], regs[9]} !== {2'b11, 16'hFFFF}) begin
      nFails++;
      $display("FAIL dec16_result: cycle=%0d wrap=%0b SP=%0h required cycle 7 wrap=1 SP=ffff",
               doneCyc, doneWrap, {regs[10], regs[9]});
    end
  endtask

  task automatic test_mov16();
    logic [3:0] expSel [6];
    expSel = '{4'd5, 4'd5, 4'd3, 4'd6, 4'd6, 4'd4};
    poke(4'd5, 8'h34);
    poke(4'd6, 8'h12);
    poke(4'd3, 8'h00);
    poke(4'd4, 8'h00);
    runCmd(3'd1, 4'd5, 4'd3);
    for (int i = 0; i < 6; i++) begin
      nChecks++;
      if (trSel[i+1] !== expSel[i]) begin
        nFails++;
        $display("FAIL mov16_sel[%0d]: got %0h required %0h", i + 1, trSel[i+1], expSel[i]);
      end
    end
    nChecks++;
    if ({regs[4], regs[3], doneWrap, doneCyc == 7} !== {16'h1234, 2'b01}) begin
      nFails++;
      $display("FAIL mov16_result: DD=%0h wrap=%0b cycle=%0d required DD=1234 wrap=0 cycle 7",
               {regs[4], regs[3]}, doneWrap, doneCyc);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] cmds [3];
    logic [3:0] srcs [3];
    logic [3:0] dsts [3];
    logic       anyStrobe;
    cmds = '{3'd6, 3'd0, 3'd1};
    srcs = '{4'd0, 4'd0, 4'd4};
    dsts = '{4'd0, 4'd11, 4'd3};
    for (int t = 0; t < 3; t++) begin
      runCmd(cmds[t], srcs[t], dsts[t]);
      anyStrobe = 1'b0;
      for (int i = 1; i <= 9; i++) anyStrobe = anyStrobe | trRd[i] | trWr[i] | trDrv[i];
      nChecks++;
      if ({errCyc == 1, doneCyc == -1, anyStrobe, trBusy[1], trReady[1], trReady[2]} !== 6'b110101) begin
        nFails++;
        $display("FAIL illegal[%0d]: errCycle=%0d doneCycle=%0d strobes=%0b readyC2=%0b required err c1, no done, no strobes, ready c2",
                 t, errCyc, doneCyc, anyStrobe, trReady[2]);
      end
    end
  endtask

  task automatic test_clr8();
    poke(4'd2, 8'hFF);
    runCmd(3'd4, 4'd0, 4'd2);
    nChecks++;
    if ({trWr[1], trDrv[1], trRd[1], trSel[1], trOut[1]} !== {3'b110, 4'd2, 8'h00}) begin
      nFails++;
      $display("FAIL clr8_write: wr=%0b drv=%0b sel=%0h out=%0h required wr=1 drv=1 sel=2 out=00",
               trWr[1], trDrv[1], trSel[1], trOut[1]);
    end
    nChecks++;
    if ({doneCyc == 2, regs[2]} !== {1'b1, 8'h00}) begin
      nFails++;
      $display("FAIL clr8_result: cycle=%0d C=%0h required cycle 2 C=00", doneCyc, regs[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] gotWr, gotDone, gotReady;
    waitReady();
    bus.cmdValid = 1'b1;
    bus.cmd      = 3'd4;
    bus.srcSel   = 4'd0;
    bus.dstSel   = 4'd0;
    step();
    for (int i = 0; i < 6; i++) begin
      gotWr[i]    = bus.regWrite;
      gotDone[i]  = bus.done;
      gotReady[i] = bus.cmdReady;
      if (i == 5) bus.cmdValid = 1'b0;
      step();
    end
    nChecks++;
    if ({gotWr, gotDone, gotReady} !== {6'b001001, 6'b010010, 6'b100100}) begin
      nFails++;
      $display("FAIL back_to_back: wr=%b done=%b ready=%b required 001001 010010 100100",
               gotWr, gotDone, gotReady);
    end
    step();
  endtask

  task automatic test_reset_mid();
    poke(4'd5, 8'hAB);
    poke(4'd6, 8'hCD);
    poke(4'd3, 8'h11);
    poke(4'd4, 8'h22);
    waitReady();
    bus.cmdValid = 1'b1;
    bus.cmd      = 3'd1;
    bus.srcSel   = 4'd5;
    bus.dstSel   = 4'd3;
    step();
    bus.cmdValid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    nChecks++;
    if ({bus.regRead, bus.regSel} !== {1'b1, 4'd6}) begin
      nFails++;
      $display("FAIL rstmid_rd2: regRead=%0b regSel=%0h required 1,6", bus.regRead, bus.regSel);
    end
    sysReset = 1'b1;
    step();
    nChecks++;
    if ({bus.cmdReady, bus.busy, bus.done, bus.err, bus.wrapOut, bus.regRead, bus.regWrite,
         bus.busDrive, bus.regSel, bus.busOut} !== {1'b1, 7'b0, 4'h0, 8'h00}) begin
      nFails++;
      $display("FAIL rstmid_outputs: ready=%0b busy=%0b rd=%0b wr=%0b sel=%0h required reset values",
               bus.cmdReady, bus.busy, bus.regRead, bus.regWrite, bus.regSel);
    end
    sysReset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    nChecks++;
    if ({regs[4], regs[3], bus.busy} !== {8'h22, 8'hAB, 1'b0}) begin
      nFails++;
      $display("FAIL rstmid_dest: DD=%0h busy=%0b required 22ab busy=0", {regs[4], regs[3]}, bus.busy);
    end
  endtask

  initial begin
    sysReset     = 1'b1;
    bus.cmdValid = 1'b0;
    bus.cmd      = 3'd0;
    bus.srcSel   = 4'd0;
    bus.dstSel   = 4'd0;
    pokeEn       = 1'b0;
    pokeIdx      = 4'd0;
    pokeVal      = 8'h00;
    test_reset();
    test_mov8();
    test_inc16();
    test_dec16();
    test_mov16();
    test_illegal();
    test_clr8();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
